// File: rtl/sa_in_skew.sv
// sa_in_skew: diagonal input skew for the systolic array west/north edges.
// Define SKEW_VALID_EN to add the per-lane valid chains and o_A_vld/o_B_vld.

module sa_skew_lane #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    logic [DEPTH-1:0][W-1:0] sr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[DEPTH-1];
endmodule

module sa_in_skew #(
    parameter int N  = 3,
    parameter int DW = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [N*DW-1:0] i_A,
    input  logic [N*DW-1:0] i_B,
    input  logic            i_push,
    input  logic            i_last,
    output logic            o_ready,
    output logic [N*DW-1:0] o_A_out,
    output logic [N*DW-1:0] o_B_out,
`ifdef SKEW_VALID_EN
    output logic [N-1:0]    o_A_vld,
    output logic [N-1:0]    o_B_vld,
`endif
    output logic            o_busy,
    output logic            o_done
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
`ifdef SKEW_VALID_EN
    localparam int LW = DW + 1;
`else
    localparam int LW = DW;
`endif

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic                 accept;
    logic [N-1:0][DW-1:0] a_in, b_in, a_out, b_out;

    assign accept  = i_push & o_ready;
    assign a_in    = i_A;
    assign b_in    = i_B;
    assign o_A_out = a_out;
    assign o_B_out = b_out;

    // o_ready/o_busy/o_done are computed from the next state so they are plain flops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            o_ready <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE, S_STREAM: begin
                    if (accept && i_last) begin
                        state   <= S_DRAIN;
                        cnt     <= CW'(N - 1);
                        o_ready <= 1'b0;
                        o_busy  <= 1'b1;
                        o_done  <= (N == 1);
                    end else if (accept) begin
                        state   <= S_STREAM;
                        o_ready <= 1'b1;
                        o_busy  <= 1'b1;
                    end else begin
                        o_ready <= 1'b1;
                        o_busy  <= (state == S_STREAM);
                    end
                end
                S_DRAIN: begin
                    if (cnt == '0) begin
                        state   <= S_IDLE;
                        o_ready <= 1'b1;
                        o_busy  <= 1'b0;
                    end else begin
                        cnt    <= cnt - 1'b1;
                        o_done <= (cnt == CW'(1));
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    o_ready <= 1'b1;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Lane k sits k+1 flops deep; idle cycles shift in zeros.
    for (genvar k = 0; k < N; k++) begin : g_lane
        logic [DW-1:0] a_z, b_z;
        logic [LW-1:0] a_d, b_d, a_q, b_q;

        assign a_z = accept ? a_in[k] : '0;
        assign b_z = accept ? b_in[k] : '0;
`ifdef SKEW_VALID_EN
        assign a_d        = {accept, a_z};
        assign b_d        = {accept, b_z};
        assign o_A_vld[k] = a_q[DW];
        assign o_B_vld[k] = b_q[DW];
`else
        assign a_d = a_z;
        assign b_d = b_z;
`endif
        assign a_out[k] = a_q[DW-1:0];
        assign b_out[k] = b_q[DW-1:0];

        sa_skew_lane #(.DEPTH(k + 1), .W(LW)) u_a (
            .i_clk  (i_clk),
            .i_rst_n(i_rst_n),
            .din    (a_d),
            .dout   (a_q)
        );
        sa_skew_lane #(.DEPTH(k + 1), .W(LW)) u_b (
            .i_clk  (i_clk),
            .i_rst_n(i_rst_n),
            .din    (b_d),
            .dout   (b_q)
        );
    end
endmodule

// File: tb/tb_sa_in_skew.sv
// Randomised + directed bench for sa_in_skew against a cycle-history model.
module tb_sa_in_skew;
    localparam int N  = 3;
    localparam int DW = 8;
    localparam int W  = N * DW;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic         i_rst_n, i_push, i_last, o_ready, o_busy, o_done;
    logic [W-1:0] i_A, i_B, o_A_out, o_B_out;
`ifdef SKEW_VALID_EN
    logic [N-1:0] o_A_vld, o_B_vld;
`endif

    sa_in_skew #(.N(N), .DW(DW)) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_A    (i_A),
        .i_B    (i_B),
        .i_push (i_push),
        .i_last (i_last),
        .o_ready(o_ready),
        .o_A_out(o_A_out),
        .o_B_out(o_B_out),
`ifdef SKEW_VALID_EN
        .o_A_vld(o_A_vld),
        .o_B_vld(o_B_vld),
`endif
        .o_busy (o_busy),
        .o_done (o_done)
    );

    logic          r1, p1, l1, rdy1, bsy1, dn1;
    logic [DW-1:0] a1, b1, ao1, bo1;
`ifdef SKEW_VALID_EN
    logic          av1, bv1;
`endif

    sa_in_skew #(.N(1), .DW(DW)) dut1 (
        .i_clk  (i_clk),
        .i_rst_n(r1),
        .i_A    (a1),
        .i_B    (b1),
        .i_push (p1),
        .i_last (l1),
        .o_ready(rdy1),
        .o_A_out(ao1),
        .o_B_out(bo1),
`ifdef SKEW_VALID_EN
        .o_A_vld(av1),
        .o_B_vld(bv1),
`endif
        .o_busy (bsy1),
        .o_done (dn1)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: hA[j]/hB[j]/hv[j] hold what was accepted j+1 cycles ago.
    logic [W-1:0] hA [N];
    logic [W-1:0] hB [N];
    logic         hv [N];
    logic [W-1:0] eA, eB;
    logic [N-1:0] eV;
    int  cyc = 0, tl = 0, rc = 0;
    bit  have_tl = 0, strm = 0, drain, acc;

    always @(negedge i_clk) begin
        if (chk_en) begin
            if (!i_rst_n) begin
                chk("rst_A", o_A_out, 0);
                chk("rst_B", o_B_out, 0);
                chk("rst_ready", o_ready, 0);
                chk("rst_busy", o_busy, 0);
                chk("rst_done", o_done, 0);
                for (int j = 0; j < N; j++) begin
                    hA[j] = '0; hB[j] = '0; hv[j] = 1'b0;
                end
                have_tl = 0; strm = 0; rc = 0;
            end else begin
                drain = have_tl && cyc > tl && cyc <= tl + N;
                for (int k = 0; k < N; k++) begin
                    eA[k*DW +: DW] = hA[k][k*DW +: DW];
                    eB[k*DW +: DW] = hB[k][k*DW +: DW];
                    eV[k]          = hv[k];
                end
                chk("A_out", o_A_out, eA);
                chk("B_out", o_B_out, eB);
`ifdef SKEW_VALID_EN
                chk("A_vld", o_A_vld, eV);
                chk("B_vld", o_B_vld, eV);
`endif
                chk("ready", o_ready, (rc > 0) && !drain);
                chk("busy", o_busy, drain || strm);
                chk("done", o_done, have_tl && cyc == tl + N);
                acc = i_push && (rc > 0) && !drain;
                for (int j = N - 1; j > 0; j--) begin
                    hA[j] = hA[j-1]; hB[j] = hB[j-1]; hv[j] = hv[j-1];
                end
                hA[0] = acc ? i_A : '0;
                hB[0] = acc ? i_B : '0;
                hv[0] = acc;
                if (acc && i_last) begin
                    have_tl = 1; tl = cyc; strm = 0;
                end else if (acc) begin
                    strm = 1;
                end
                rc++;
            end
            cyc++;
        end
    end

    task automatic drv(input logic p, input logic l, input logic [W-1:0] a, input logic [W-1:0] b);
        i_push = p; i_last = l; i_A = a; i_B = b;
    endtask

    initial begin
        i_rst_n = 0; drv(0, 0, 0, 0);
        r1 = 0; p1 = 0; l1 = 0; a1 = 0; b1 = 0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk) #1;
        chk("n1_rst_A", ao1, 0);
        chk("n1_rst_ready", rdy1, 0);
        chk("n1_rst_done", dn1, 0);
        @(posedge i_clk) #1 i_rst_n = 1; r1 = 1;
        @(negedge i_clk) #1 chk("rel_ready0", o_ready, 0);
        @(posedge i_clk) #1;
        @(negedge i_clk) #1 chk("rel_ready1", o_ready, 1);

        // N=1 instance: push+last, data and done together one edge later
        @(posedge i_clk) #1 p1 = 1; l1 = 1; a1 = 8'hA5; b1 = 8'h5A;
        @(posedge i_clk) #1 p1 = 0; l1 = 0; a1 = 8'hFF;
        chk("n1_A", ao1, 64'hA5);
        chk("n1_B", bo1, 64'h5A);
        chk("n1_done", dn1, 1);
        chk("n1_ready_lo", rdy1, 0);
`ifdef SKEW_VALID_EN
        chk("n1_vld", av1, 1);
`endif
        @(posedge i_clk) #1;
        chk("n1_ready_hi", rdy1, 1);
        chk("n1_done_lo", dn1, 0);
        chk("n1_A_zero", ao1, 0);

        // single matrix, back-to-back
        @(posedge i_clk) #1 drv(1, 0, 24'h030201, 24'h0C0B0A);
        @(posedge i_clk) #1 drv(1, 0, 24'h060504, 24'h0F0E0D);
        @(negedge i_clk) #1 chk("m_l0_c1", o_A_out[7:0], 64'h01);
        @(posedge i_clk) #1 drv(1, 1, 24'h090807, 24'h121110);
        @(negedge i_clk) #1 chk("m_l0_c2", o_A_out[7:0], 64'h04);
        chk("m_l1_c2", o_A_out[15:8], 64'h02);
        @(posedge i_clk) #1 drv(1, 0, 24'hEEEEEE, 24'hEEEEEE);
        @(negedge i_clk) #1 chk("m_l0_c3", o_A_out[7:0], 64'h07);
        chk("m_l2_c3", o_A_out[23:16], 64'h03);
        chk("m_ready_c3", o_ready, 0);
        @(posedge i_clk) #1 drv(0, 0, 0, 0);
        @(negedge i_clk) #1 chk("m_l2_c4", o_A_out[23:16], 64'h06);
        chk("m_done_c4", o_done, 0);
        @(posedge i_clk) #1;
        @(negedge i_clk) #1 chk("m_l2_c5", o_A_out[23:16], 64'h09);
        chk("m_Bl2_c5", o_B_out[23:16], 64'h12);
        chk("m_done_c5", o_done, 1);
        chk("m_ready_c5", o_ready, 0);
        @(posedge i_clk) #1;
        @(negedge i_clk) #1 chk("m_ready_c6", o_ready, 1);
        chk("m_done_c6", o_done, 0);

        // bubble: push, idle, push(last)
        @(posedge i_clk) #1 drv(1, 0, 24'h332211, 24'h665544);
        @(posedge i_clk) #1 drv(0, 0, 0, 0);
        @(posedge i_clk) #1 drv(1, 1, 24'h998877, 24'hCCBBAA);
        @(posedge i_clk) #1 drv(0, 0, 0, 0);
        repeat (N + 2) @(posedge i_clk);

        // push held high through drain; data changes every cycle
        for (int c = 0; c < 3 * N; c++) begin
            @(posedge i_clk) #1 drv(1, c == 0 || c == 2 * N, W'($urandom()), W'($urandom()));
        end
        @(posedge i_clk) #1 drv(0, 0, 0, 0);
        repeat (N + 2) @(posedge i_clk);

        // async reset mid-drain
        @(posedge i_clk) #1 drv(1, 1, 24'h4D4C4B, 24'h7A7B7C);
        @(posedge i_clk) #1 drv(0, 0, 0, 0);
        @(posedge i_clk) #3 i_rst_n = 0;
        #1 chk("mid_rst_A", o_A_out, 0);
        chk("mid_rst_ready", o_ready, 0);
        chk("mid_rst_busy", o_busy, 0);
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1;

        // random traffic
        repeat (600) begin
            @(posedge i_clk) #1 drv($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                                   W'($urandom()), W'($urandom()));
        end
        @(posedge i_clk) #1 drv(0, 0, 0, 0);
        repeat (N + 3) @(posedge i_clk);
        @(posedge i_clk) #2 chk_en = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
